// File: rtl/sbox_share_arb_pkg.sv
// Shared definitions for the shared S-box word substitution slice.
//   WORD_W / BYTE_W : substitution word and byte widths (word fixed at 4 bytes)
//   clog2()         : index width helper, never returns less than 1
//   sbox_byte()     : AES forward S-box lookup for one byte
//   sbox_word()     : four independent byte lookups, byte k in place
package sbox_share_arb_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Entry 0 is listed first.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [BYTE_W-1:0] sbox_byte(input logic [BYTE_W-1:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [WORD_W-1:0] sbox_word(input logic [WORD_W-1:0] x);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < WORD_W / BYTE_W; k++) begin
            w[k*BYTE_W +: BYTE_W] = sbox_byte(x[k*BYTE_W +: BYTE_W]);
        end
        return w;
    endfunction

endpackage

// File: rtl/sbox_share_arb_if.sv
// Request/response bundle between NUM_REQ requesters and the shared S-box.
//   req_valid/req_ready/req_data : per-requester word requests (operand i at [i*32 +: 32])
//   rsp_valid/rsp_ready          : per-requester result handshake, rsp_valid one-hot
//   rsp_data                     : shared result bus, meaningful for the owner only
//
// Handshake rules: a transfer happens at a rising edge where valid && ready.
// req_ready may depend combinationally on req_valid, so requesters assert
// req_valid without waiting for req_ready and hold valid/data stable until the
// transfer. Only the owning requester's rsp_ready bit is observed.
interface sbox_share_arb_if #(
    parameter int NUM_REQ = 2
);
    import sbox_share_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*WORD_W-1:0] req_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [WORD_W-1:0]         rsp_data;
    logic [NUM_REQ-1:0]        rsp_ready;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sbox_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   enable    : when low no grant is issued
//   ptr       : index of the highest-priority requester
//   grant     : one-hot grant (or zero)
//   grant_idx : index of the granted requester (0 when no grant)
// The search starts at ptr and walks upward with wrap to NUM_REQ-1 -> 0.
module rr_arbiter
    import sbox_share_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W:0]   pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // Candidate position ptr+off, folded back into 0..NUM_REQ-1.
            pos = {1'b0, ptr} + (IDX_W+1)'(off);
            if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (enable && !found && req[i] && (pos == (IDX_W+1)'(i))) begin
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sbox_share_arb.sv
// Shares one registered 4-byte S-box unit (S4) between NUM_REQ requesters.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sbox_share_arb_if.slave (requests in, one-hot results out)
// One word may issue per cycle. A word issues only when no result is pending
// or the pending result is being accepted on the same edge, so a stalled
// owner blocks every requester and its result and data are held intact.
module sbox_share_arb
    import sbox_share_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    sbox_share_arb_if.slave   bus
);

    logic                 pend_q;
    logic [IDX_W-1:0]     owner_q;
    logic [WORD_W-1:0]    op_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [WORD_W-1:0]    s4_q;

    logic                 can_issue;
    logic                 arb_en;
    logic                 issue;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     ptr_next;
    logic [WORD_W-1:0]    s4_in;

    assign can_issue = !pend_q || bus.rsp_ready[owner_q];
    // Gating with rst_n keeps req_ready low for the whole reset interval.
    assign arb_en    = rst_n && can_issue;
    assign issue     = |grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .enable    (arb_en),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // S4 input: the winner's operand on an issue cycle, otherwise the held
    // operand, so S4 keeps producing the same result while stalled or idle.
    always_comb begin
        s4_in = op_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) s4_in = bus.req_data[i*WORD_W +: WORD_W];
        end
    end

    assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 1'b0;
            owner_q  <= '0;
            op_q     <= '0;
            rr_ptr_q <= '0;
        end else if (issue) begin
            pend_q   <= 1'b1;
            owner_q  <= grant_idx;
            op_q     <= s4_in;
            rr_ptr_q <= ptr_next;
        end else if (pend_q && bus.rsp_ready[owner_q]) begin
            pend_q   <= 1'b0;
        end
    end

    // S4 register carries no reset; it tracks op_q (zero) during reset.
    always_ff @(posedge clk) begin
        s4_q <= sbox_word(s4_in);
    end

    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = pend_q && (owner_q == IDX_W'(i));
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_data  = s4_q;

endmodule
